// File: rtl/pcie_mfb2avst.sv
// pcie_mfb2avst: multi-region MFB to segmented Avalon-ST converter for the PCIe TX path.
// Per-region packet tracking feeds a FWFT buffer drained by a ready-latency-aware scheduler.
module pcie_mfb2avst #(
  parameter int    REGIONS       = 2,
  parameter int    REGION_SIZE   = 1,
  parameter int    BLOCK_SIZE    = 8,
  parameter int    ITEM_WIDTH    = 32,
  parameter int    META_WIDTH    = 128,
  parameter int    READY_LATENCY = 3,
  parameter int    FIFO_DEPTH    = 32,
  parameter string DEVICE        = "AGILEX",
  localparam int   RI            = REGION_SIZE*BLOCK_SIZE,
  localparam int   EW            = (RI > 1) ? $clog2(RI) : 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [REGIONS*RI*ITEM_WIDTH-1:0]   RX_MFB_DATA,
  input  logic [REGIONS*META_WIDTH-1:0]      RX_MFB_META,
  input  logic [REGIONS-1:0]                 RX_MFB_SOF,
  input  logic [REGIONS-1:0]                 RX_MFB_EOF,
  input  logic [REGIONS*EW-1:0]              RX_MFB_EOF_POS,
  input  logic                               RX_MFB_SRC_RDY,
  output logic                               RX_MFB_DST_RDY,
  output logic [REGIONS*RI*ITEM_WIDTH-1:0]   TX_AVST_DATA,
  output logic [REGIONS*META_WIDTH-1:0]      TX_AVST_META,
  output logic [REGIONS-1:0]                 TX_AVST_SOP,
  output logic [REGIONS-1:0]                 TX_AVST_EOP,
  output logic [REGIONS*EW-1:0]              TX_AVST_EMPTY,
  output logic [REGIONS-1:0]                 TX_AVST_VALID,
  input  logic                               TX_AVST_READY
);

  localparam int DW = REGIONS*RI*ITEM_WIDTH;
  localparam int MW = REGIONS*META_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [EW-1:0] LAST_ITEM = EW'(RI-1);

  typedef struct packed {
    logic [DW-1:0]         data;
    logic [MW-1:0]         meta;
    logic [REGIONS-1:0]    sop;
    logic [REGIONS-1:0]    eop;
    logic [REGIONS*EW-1:0] empty;
    logic [REGIONS-1:0]    v;
  } entry_t;

  // DEVICE only matters for vendor FIFO primitives; the generic array below is device independent.
  logic dev_unused;
  assign dev_unused = (DEVICE == "AGILEX");

  entry_t        in_entry, head;
  entry_t        mem [FIFO_DEPTH];
  logic          in_pkt, in_pkt_next, dst_rdy, xfer, push, pop, rdy_tap;
  logic [AW:0]   count, count_next;
  logic [AW-1:0] wr_ptr, rd_ptr;

  always_comb begin
    logic carry;
    in_entry      = '0;
    in_entry.data = RX_MFB_DATA;
    in_entry.meta = RX_MFB_META;
    carry         = in_pkt;
    for (int r = 0; r < REGIONS; r++) begin
      in_entry.v[r]   = RX_MFB_SOF[r] | carry;
      in_entry.sop[r] = RX_MFB_SOF[r] & in_entry.v[r];
      in_entry.eop[r] = RX_MFB_EOF[r] & in_entry.v[r];
      if (RX_MFB_EOF[r])
        in_entry.empty[r*EW +: EW] = LAST_ITEM - RX_MFB_EOF_POS[r*EW +: EW];
      carry = in_entry.v[r] & ~RX_MFB_EOF[r];
    end
    in_pkt_next = carry;
  end

  // Words with no valid region are accepted but never occupy a buffer slot.
  assign RX_MFB_DST_RDY = dst_rdy & ~RST;
  assign xfer       = RX_MFB_SRC_RDY & RX_MFB_DST_RDY;
  assign push       = xfer & (|in_entry.v);
  assign pop        = rdy_tap & (count != '0);
  assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign head       = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (RST) begin
      in_pkt  <= 1'b0;
      count   <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      dst_rdy <= 1'b1;
    end else begin
      if (xfer) in_pkt <= in_pkt_next;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      dst_rdy <= (count_next < (AW+1)'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  // The tap sees READY delayed so a popped beat lands exactly READY_LATENCY cycles after it.
  if (READY_LATENCY == 1) begin : g_rdy_direct
    assign rdy_tap = TX_AVST_READY;
  end else begin : g_rdy_sr
    logic [READY_LATENCY-2:0] rdy_sr;
    always_ff @(posedge CLK) begin
      if (RST) begin
        rdy_sr <= '0;
      end else begin
        rdy_sr[0] <= TX_AVST_READY;
        for (int i = 1; i < READY_LATENCY-1; i++) rdy_sr[i] <= rdy_sr[i-1];
      end
    end
    assign rdy_tap = rdy_sr[READY_LATENCY-2];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      TX_AVST_DATA  <= '0;
      TX_AVST_META  <= '0;
      TX_AVST_EMPTY <= '0;
      TX_AVST_SOP   <= '0;
      TX_AVST_EOP   <= '0;
      TX_AVST_VALID <= '0;
    end else if (pop) begin
      TX_AVST_DATA  <= head.data;
      TX_AVST_META  <= head.meta;
      TX_AVST_EMPTY <= head.empty;
      TX_AVST_SOP   <= head.sop;
      TX_AVST_EOP   <= head.eop;
      TX_AVST_VALID <= head.v;
    end else begin
      TX_AVST_SOP   <= '0;
      TX_AVST_EOP   <= '0;
      TX_AVST_VALID <= '0;
    end
  end

endmodule

// File: tb/tb_pcie_mfb2avst.sv
// Testbench for pcie_mfb2avst: directed plan steps plus randomized packet traffic,
// checked against a packet-level model that predicts every TX beat and DST_RDY.
module tb_pcie_mfb2avst;
  localparam int RL    = 3;
  localparam int DEPTH = 32;
  localparam int DW    = 512;
  localparam int MW    = 256;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [DW-1:0] RX_MFB_DATA = '0;
  logic [MW-1:0] RX_MFB_META = '0;
  logic [1:0]    RX_MFB_SOF = '0, RX_MFB_EOF = '0;
  logic [5:0]    RX_MFB_EOF_POS = '0;
  logic          RX_MFB_SRC_RDY = 1'b0;
  logic          RX_MFB_DST_RDY;
  logic [DW-1:0] TX_AVST_DATA;
  logic [MW-1:0] TX_AVST_META;
  logic [1:0]    TX_AVST_SOP, TX_AVST_EOP, TX_AVST_VALID;
  logic [5:0]    TX_AVST_EMPTY;
  logic          TX_AVST_READY = 1'b0;

  pcie_mfb2avst #(
    .REGIONS(2), .REGION_SIZE(1), .BLOCK_SIZE(8), .ITEM_WIDTH(32), .META_WIDTH(128),
    .READY_LATENCY(RL), .FIFO_DEPTH(DEPTH), .DEVICE("AGILEX")
  ) dut (
    .CLK(CLK), .RST(RST),
    .RX_MFB_DATA(RX_MFB_DATA), .RX_MFB_META(RX_MFB_META),
    .RX_MFB_SOF(RX_MFB_SOF), .RX_MFB_EOF(RX_MFB_EOF), .RX_MFB_EOF_POS(RX_MFB_EOF_POS),
    .RX_MFB_SRC_RDY(RX_MFB_SRC_RDY), .RX_MFB_DST_RDY(RX_MFB_DST_RDY),
    .TX_AVST_DATA(TX_AVST_DATA), .TX_AVST_META(TX_AVST_META),
    .TX_AVST_SOP(TX_AVST_SOP), .TX_AVST_EOP(TX_AVST_EOP), .TX_AVST_EMPTY(TX_AVST_EMPTY),
    .TX_AVST_VALID(TX_AVST_VALID), .TX_AVST_READY(TX_AVST_READY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    logic [MW-1:0] meta;
    logic [1:0]    v, sop, eop;
    logic [5:0]    empty;
    int            cyc;
  } beat_t;

  beat_t exp_q[$];
  bit    ready_hist [0:8191];
  int    cyc = 0;
  int    vectors = 0, miscompares = 0;
  bit    armed = 0;

  // Word currently presented to the source side and the segment layout it must produce.
  logic [DW-1:0] w_data = '0;
  logic [MW-1:0] w_meta = '0;
  logic [1:0]    w_sof = '0, w_eof = '0, w_v = '0;
  logic [5:0]    w_pos = '0, w_empty = '0;
  int            gen_rem = 0, pend_rem = 0;
  bit            have_pend = 0;

  task automatic rand_payload();
    for (int k = 0; k < DW/32; k++) w_data[k*32 +: 32] = $urandom();
    for (int k = 0; k < MW/32; k++) w_meta[k*32 +: 32] = $urandom();
  endtask

  task automatic set_word(input logic [1:0] sof, input logic [1:0] eof, input logic [5:0] pos,
                          input logic [1:0] v, input logic [5:0] empty);
    rand_payload();
    w_sof = sof; w_eof = eof; w_pos = pos; w_v = v; w_empty = empty;
  endtask

  // Lay packets of random length (1..40 dwords) into regions, 8 dwords per region.
  task automatic gen_word(input int idle_pct);
    int rem, n;
    rem = gen_rem;
    rand_payload();
    w_sof = '0; w_eof = '0; w_v = '0; w_empty = '0;
    w_pos = 6'($urandom());
    for (int r = 0; r < 2; r++) begin
      if (rem == 0 && $urandom_range(99) >= idle_pct) begin
        rem = $urandom_range(40, 1);
        w_sof[r] = 1'b1;
      end
      if (rem > 0) begin
        w_v[r] = 1'b1;
        n = (rem > 8) ? 8 : rem;
        rem -= n;
        if (rem == 0) begin
          w_eof[r] = 1'b1;
          w_pos[r*3 +: 3] = 3'(n - 1);
          w_empty[r*3 +: 3] = 3'(8 - n);
        end
      end
    end
    pend_rem = rem;
  endtask

  task automatic checkOutput();
    beat_t b;
    bit due;
    due = (cyc >= RL) && ready_hist[cyc-RL] && (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2);
    if (due) begin
      b = exp_q.pop_front();
      vectors++;
      assert ({TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP, TX_AVST_EMPTY} === {b.v, b.sop, b.eop, b.empty})
      else begin
        miscompares++;
        $error("[TB] FAIL beat_ctrl cyc %0d: observed %h expected %h", cyc,
               {TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP, TX_AVST_EMPTY}, {b.v, b.sop, b.eop, b.empty});
      end
      vectors++;
      assert (TX_AVST_DATA === b.data) else begin
        miscompares++;
        $error("[TB] FAIL beat_data cyc %0d: observed %h expected %h", cyc, TX_AVST_DATA, b.data);
      end
      vectors++;
      assert (TX_AVST_META === b.meta) else begin
        miscompares++;
        $error("[TB] FAIL beat_meta cyc %0d: observed %h expected %h", cyc, TX_AVST_META, b.meta);
      end
    end else begin
      vectors++;
      assert ({TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP} === 6'b0) else begin
        miscompares++;
        $error("[TB] FAIL idle_slot cyc %0d: observed %b expected 000000", cyc,
               {TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP});
      end
    end
  endtask

  task automatic applyStimulus(input bit rst_i, input bit rdy_i, input bit src_i, output bit acc);
    beat_t b;
    bit exp_rdy;
    @(negedge CLK);
    cyc++;
    if (armed) checkOutput();
    RST = rst_i;
    TX_AVST_READY = rdy_i;
    RX_MFB_SRC_RDY = src_i;
    RX_MFB_DATA = w_data;
    RX_MFB_META = w_meta;
    RX_MFB_SOF = w_sof;
    RX_MFB_EOF = w_eof;
    RX_MFB_EOF_POS = w_pos;
    ready_hist[cyc] = rdy_i && !rst_i;
    if (rst_i) begin
      for (int i = 0; i <= RL && i <= cyc; i++) ready_hist[cyc-i] = 1'b0;
      exp_q.delete();
      armed = 1;
    end
    #1;
    exp_rdy = !rst_i && (exp_q.size() < DEPTH);
    vectors++;
    assert (RX_MFB_DST_RDY === exp_rdy) else begin
      miscompares++;
      $error("[TB] FAIL dst_rdy cyc %0d: observed %b expected %b", cyc, RX_MFB_DST_RDY, exp_rdy);
    end
    acc = src_i && RX_MFB_DST_RDY && !rst_i;
    if (acc && w_v != 2'b00) begin
      b.data = w_data; b.meta = w_meta; b.v = w_v;
      b.sop = w_sof; b.eop = w_eof; b.empty = w_empty; b.cyc = cyc;
      exp_q.push_back(b);
    end
  endtask

  // rdy_mode: 0 = held low, 1 = held high, 2 = toggling, other = random ~70% high.
  task automatic stream(input int n, input int rdy_mode, input int src_pct, input int idle_pct);
    bit acc, rdy;
    for (int i = 0; i < n; i++) begin
      if (!have_pend) begin
        gen_word(idle_pct);
        have_pend = 1;
      end
      case (rdy_mode)
        0:       rdy = 1'b0;
        1:       rdy = 1'b1;
        2:       rdy = (i % 2 == 0);
        default: rdy = ($urandom_range(99) < 70);
      endcase
      applyStimulus(1'b0, rdy, $urandom_range(99) < src_pct, acc);
      if (acc) begin
        gen_rem = pend_rem;
        have_pend = 0;
      end
    end
  endtask

  task automatic finish_packet();
    for (int g = 0; g < 200 && (gen_rem != 0 || have_pend); g++) stream(1, 1, 100, 100);
  endtask

  task automatic drain(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    bit acc;
    int seen;
    logic [MW-1:0] sent_meta;

    // Reset and reset-state values
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, acc);
    vectors++;
    assert ({TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP, TX_AVST_EMPTY} === 12'b0) else begin
      miscompares++;
      $error("[TB] FAIL reset_ctrl: observed %h expected 000",
             {TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP, TX_AVST_EMPTY});
    end
    vectors++;
    assert (TX_AVST_DATA === '0 && TX_AVST_META === '0) else begin
      miscompares++;
      $error("[TB] FAIL reset_payload: observed data %h meta %h expected zero", TX_AVST_DATA, TX_AVST_META);
    end

    // Single-region packet, EOF_POS=5
    drain(4);
    set_word(2'b01, 2'b01, 6'b110_101, 2'b01, 6'b000_010);
    sent_meta = w_meta;
    applyStimulus(1'b0, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 1'b0, acc);
    vectors++;
    assert ({TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP} === 6'b01_01_01) else begin
      miscompares++;
      $error("[TB] FAIL single_region: observed %b expected 010101", {TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP});
    end
    vectors++;
    assert (TX_AVST_EMPTY[2:0] === 3'd2 && TX_AVST_META[127:0] === sent_meta[127:0]) else begin
      miscompares++;
      $error("[TB] FAIL single_empty_meta: observed %0d %h expected 2 %h",
             TX_AVST_EMPTY[2:0], TX_AVST_META[127:0], sent_meta[127:0]);
    end

    // 20-dword packet over two words, then a packet starting in region 1 only
    set_word(2'b01, 2'b00, 6'b011_110, 2'b11, 6'b000_000);
    applyStimulus(1'b0, 1'b1, 1'b1, acc);
    set_word(2'b00, 2'b01, 6'b110_011, 2'b01, 6'b000_100);
    applyStimulus(1'b0, 1'b1, 1'b1, acc);
    set_word(2'b10, 2'b10, 6'b111_010, 2'b10, 6'b000_000);
    applyStimulus(1'b0, 1'b1, 1'b1, acc);
    vectors++;
    assert ({TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP} === 6'b11_01_00) else begin
      miscompares++;
      $error("[TB] FAIL span_word1: observed %b expected 110100", {TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP});
    end
    applyStimulus(1'b0, 1'b1, 1'b0, acc);
    vectors++;
    assert ({TX_AVST_VALID, TX_AVST_EOP, TX_AVST_EMPTY} === 10'b01_01_000100) else begin
      miscompares++;
      $error("[TB] FAIL span_word2: observed %b expected 0101000100", {TX_AVST_VALID, TX_AVST_EOP, TX_AVST_EMPTY});
    end
    applyStimulus(1'b0, 1'b1, 1'b0, acc);
    vectors++;
    assert ({TX_AVST_VALID, TX_AVST_SOP} === 4'b10_10) else begin
      miscompares++;
      $error("[TB] FAIL region1_start: observed %b expected 1010", {TX_AVST_VALID, TX_AVST_SOP});
    end
    drain(6);

    // READY low for 100 cycles while streaming, then drain
    stream(100, 0, 100, 0);
    vectors++;
    assert (RX_MFB_DST_RDY === 1'b0) else begin
      miscompares++;
      $error("[TB] FAIL full_backpressure: observed %b expected 0", RX_MFB_DST_RDY);
    end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, acc);
      if (TX_AVST_VALID != 2'b00) seen++;
    end
    vectors++;
    assert (seen === 32 && RX_MFB_DST_RDY === 1'b1) else begin
      miscompares++;
      $error("[TB] FAIL drain_count: observed %0d beats dst_rdy %b expected 32 beats dst_rdy 1", seen, RX_MFB_DST_RDY);
    end

    // Toggling READY with a full FIFO
    finish_packet();
    drain(40);
    stream(40, 0, 100, 0);
    stream(200, 2, 100, 20);
    finish_packet();
    drain(60);

    // Reset mid-packet with a backlog
    stream(10, 0, 100, 0);
    finish_packet();
    drain(40);
    stream(6, 0, 100, 0);
    set_word(2'b01, 2'b00, 6'b000_000, 2'b11, 6'b000_000);
    applyStimulus(1'b0, 1'b0, 1'b1, acc);
    have_pend = 0;
    gen_rem = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 1'b1, 1'b0, acc);
    vectors++;
    assert ({TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP} === 6'b0 && TX_AVST_DATA === '0 && TX_AVST_EMPTY === '0)
    else begin
      miscompares++;
      $error("[TB] FAIL reset_midpkt: observed ctrl %b empty %h expected zero",
             {TX_AVST_VALID, TX_AVST_SOP, TX_AVST_EOP}, TX_AVST_EMPTY);
    end
    set_word(2'b10, 2'b10, 6'b111_101, 2'b10, 6'b000_000);
    applyStimulus(1'b0, 1'b1, 1'b1, acc);
    drain(10);

    // Randomized traffic with random READY and source gaps
    stream(600, 3, 80, 25);
    finish_packet();
    drain(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pcie_mfb2avst.md
# pcie_mfb2avst

Converts a multi-region MFB stream into the segmented Avalon-ST interface of the PCIe hard IP. It is the transmit-side counterpart of the PCIe Avalon-ST-to-MFB converter. The block sits between the DMA/MI MFB logic and the PCIe core TX Avalon-ST port. It honours the Avalon ready latency through a credit-free output scheduler and an internal buffer FIFO.

## Interface
Parameters:
- REGIONS, 2, number of MFB regions = Avalon segments
- REGION_SIZE, 1, blocks per region
- BLOCK_SIZE, 8, items per block
- ITEM_WIDTH, 32, bits per item (one dword)
- META_WIDTH, 128, metadata bits per region
- READY_LATENCY, 3, Avalon ready latency in cycles; legal range 1..32
- FIFO_DEPTH, 32, buffer words; power of two, >= 4
- DEVICE, "AGILEX", target device string passed to the FIFO

Ports (RI = REGION_SIZE*BLOCK_SIZE, EW = log2(RI)):
- CLK  in  1  clock; one clock domain only
- RST  in  1  synchronous, active-high reset
- RX_MFB_DATA  in  REGIONS*RI*ITEM_WIDTH  data word
- RX_MFB_META  in  REGIONS*META_WIDTH  per-region metadata, valid with SOF
- RX_MFB_SOF  in  REGIONS  start of frame; SOF_POS is implicitly 0
- RX_MFB_EOF  in  REGIONS  end of frame
- RX_MFB_EOF_POS  in  REGIONS*EW  last valid item in region
- RX_MFB_SRC_RDY  in  1  word valid
- RX_MFB_DST_RDY  out  1  block can accept a word
- TX_AVST_DATA  out  REGIONS*RI*ITEM_WIDTH  segment data
- TX_AVST_META  out  REGIONS*META_WIDTH  header/meta, valid with SOP
- TX_AVST_SOP  out  REGIONS  start of packet
- TX_AVST_EOP  out  REGIONS  end of packet
- TX_AVST_EMPTY  out  REGIONS*EW  unused items at segment end
- TX_AVST_VALID  out  REGIONS  per-segment valid
- TX_AVST_READY  in  1  sink ready, subject to READY_LATENCY

## Operation
- Input constraints:
  - Every packet starts at item 0 of a region.
  - A region holding both SOF and EOF holds one whole packet.
  - The source never puts an EOF of one packet and an SOF of the next in the same region.
- Input transfer occurs when SRC_RDY=1 and DST_RDY=1.
- Stage 1 (registered):
  - Per-region valid: v[r] = SOF[r] or inpkt[r].
  - inpkt[0] = in_pkt register.
  - inpkt[r+1] = (SOF[r] or inpkt[r]) and not EOF[r].
  - On transfer, in_pkt <= inpkt[REGIONS].
  - EMPTY[r] = RI-1-EOF_POS[r] when EOF[r]=1, else 0. Unsigned EW-bit arithmetic, no overflow possible.
  - SOP/EOP are SOF/EOF masked by v. META is copied unchanged.
- A transferred word with v=0 in all regions is dropped and not written to the FIFO.
- FIFO: first-word-fall-through, FIFO_DEPTH entries, each entry holds {DATA, META, SOP, EOP, EMPTY, v}.
- DST_RDY = 1 when FIFO occupancy, including any word held in stage 1, is < FIFO_DEPTH. DST_RDY is registered from occupancy.
- Output scheduler:
  - rdy_sr is a shift register of READY_LATENCY-1 stages fed by TX_AVST_READY (for READY_LATENCY=1 it is READY itself).
  - Pop when the rdy_sr tap is 1 and the FIFO is non-empty.
  - Output registers load the popped entry; TX_AVST_VALID <= v.
  - On any cycle without a pop, TX_AVST_VALID <= 0, SOP/EOP <= 0, and DATA/META/EMPTY hold their previous values.
- Rule: TX_AVST_VALID in cycle t is non-zero only if TX_AVST_READY was 1 in cycle t-READY_LATENCY. Every such beat is consumed by the sink. There is no further output backpressure.

## Timing
- Reset values:
  - DST_RDY=0 during reset, then 1 from the first cycle after RST deasserts.
  - TX_AVST_VALID/SOP/EOP = 0; DATA/META/EMPTY = 0.
  - FIFO is empty; in_pkt=0; rdy_sr is all 0.
- Latency: a word accepted in cycle t appears on TX earliest in cycle t+2, provided TX_AVST_READY was 1 in cycle t+2-READY_LATENCY.
- Throughput: one word per cycle while READY is held at 1.
- FIFO full: DST_RDY=0 in the cycle after occupancy reaches FIFO_DEPTH. Simultaneous push and pop while full is not possible because DST_RDY is already low.
- FIFO empty with the rdy_sr tap at 1: no pop, the VALID slot is lost, no error.
- Reset mid-packet: all buffered data is discarded and in_pkt is cleared. No TX_AVST_VALID appears for at least READY_LATENCY cycles after reset ends.
- Packets spanning words: in_pkt carries the packet across words. Segments inside a packet have VALID=1 with SOP=EOP=0.

## Test plan
- REGIONS=2, RI=8, READY_LATENCY=3, READY constantly 1. Send a 1-region packet (SOF[0], EOF[0], EOF_POS=5) -> two cycles later VALID=01, SOP=01, EOP=01, EMPTY[0]=2, META matches.
- 20-dword packet starting at region 0, ending at region 0 of the second word with EOF_POS=3 -> word 1 VALID=11, SOP=01; word 2 VALID=01, EOP=01, EMPTY=4.
- READY toggles 1,0,1,0 with a full FIFO -> VALID never asserted 3 cycles after a READY=0; beats are delivered in order with no loss or duplication.
- READY held 0 for 100 cycles while the source streams -> DST_RDY drops after 32 words; after READY returns, 32 words drain in order and DST_RDY returns.
- RST asserted one cycle mid-packet -> all outputs 0, FIFO empty. The next packet starts with SOP, and there are no segments from the aborted packet.
- Idle gap: region 0 carries EOF, region 1 carries no SOF -> VALID=01. A following word with SOF[1] only -> VALID=10.
